dadda_8: RTL and testbench
==========================

DADDA_8 -- requirements
Module: dadda_8

Interface
REQ-001 Parameters: none; all widths are fixed package constants (A_W=8, B_W=8, P_W=16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 A  input  8  unsigned multiplicand.
REQ-005 B  input  8  unsigned multiplier.
REQ-006 y  output  16  registered unsigned product A*B.

Function
REQ-007 The block SHALL compute the exact unsigned product y = A*B over 16 bits with no truncation; the maximum result is 0xFE01.
REQ-008 Partial products SHALL be generated as 64 AND terms pp[i][j] = A[j] & B[i], placed at column i+j.
REQ-009 Reduction SHALL follow the Dadda height sequence 8 -> 6 -> 4 -> 3 -> 2.
REQ-010 Each reduction stage SHALL use only full adders (3:2 carry-save) and half adders (2:2).
REQ-011 Each reduction stage SHALL use the minimum number of adders needed to meet the next column-height target.
REQ-012 The final two rows SHALL be summed by a 14-bit ripple carry-propagate adder spanning columns 1..14.
REQ-013 Column 0 SHALL pass pp[0][0] directly to the result.
REQ-014 Column 15 SHALL take the final carry-out of the carry-propagate adder.
REQ-015 Default build: the multiplier tree SHALL be combinational from A/B to a single output register.
REQ-016 Default build: y SHALL update on every rising clk edge with rst=0, to the product of the A/B values present at that edge.
REQ-017 Default build latency SHALL be 1 cycle.
REQ-018 Throughput SHALL be one product per cycle.
REQ-019 There SHALL be no handshake, valid, or stall signals; every cycle's inputs are consumed.
REQ-020 No internal state other than the pipeline registers SHALL exist; back-to-back differing operands SHALL give independent results.

Reset
REQ-021 While rst=1 at a rising clk edge, y (and the input register, when enabled) SHALL load 0.
REQ-022 In the cycle after rst deasserts, y SHALL reflect the A/B sampled at that first non-reset edge, plus the pipeline latency.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight products; no partial or stale value SHALL appear after reset.
REQ-024 y SHALL be undefined only before the first clock edge.

Configuration
REQ-025 Macro DADDA_8_IN_REG_EN, when defined, SHALL add an 8+8-bit input register capturing A and B, cleared by rst.
REQ-026 With DADDA_8_IN_REG_EN defined, the tree SHALL be fed from the input register and total latency SHALL be 2 cycles, at one product per cycle.
REQ-027 With DADDA_8_IN_REG_EN undefined, no input register SHALL exist and latency SHALL be 1 cycle.
REQ-028 Results SHALL be numerically identical in both configurations, differing only in latency.

Structure
REQ-029 Package dadda_8_pkg SHALL hold the constants A_W, B_W, P_W and the Dadda stage-height list {6,4,3,2}.
REQ-030 Package dadda_8_pkg SHALL hold a localparam LATENCY that follows DADDA_8_IN_REG_EN.
REQ-031 One sub-module, dadda_fa (1-bit full adder: a, b, cin -> sum, cout), SHALL be instantiated for every 3:2 reduction cell and carry-propagate bit.
REQ-032 Half adders SHALL be inline logic, not a separate sub-module.
REQ-033 The reduction tree SHALL be explicitly instantiated per stage, not written as a behavioural '*'.

Verification
REQ-034 Hold rst=1 for 2 cycles with A=0xFF, B=0xFF -> y=0x0000 throughout reset; after release and LATENCY cycles, y=0xFE01 (65025).
REQ-035 Apply A=0x00, B=0xB7, then A=0x01, B=0xA5, then A=0x80, B=0x02 on consecutive cycles -> y sequence 0x0000, 0x00A5, 0x0100, each appearing LATENCY cycles after its inputs.
REQ-036 Apply A=0xAA, B=0x55 -> y=0x3872 (14450); apply A=0x0F, B=0xF0 -> y=0x0E10 (3600).
REQ-037 Apply at least 15 random A/B pairs, plus an exhaustive 65536-pair sweep -> y equals A*B at LATENCY cycles in every case; any mismatch prints "*ERROR*".
REQ-038 Assert rst for one cycle in the middle of a random stream -> the next y=0; the following y values match only the inputs applied after reset.
REQ-039 Run REQ-034..REQ-038 in both configurations, with and without DADDA_8_IN_REG_EN -> all pass with latency 1 and 2 respectively.

Source files
------------

// File: rtl/dadda_8_pkg.sv
// dadda_8_pkg -- shared constants and tree-shape helper for the 8x8 Dadda
// multiplier.
//   A_W, B_W, P_W : operand and product widths
//   DADDA_H       : column-height targets after each reduction stage
//   LATENCY       : cycles from A/B to y (2 when DADDA_8_IN_REG_EN is defined)
//   tree_info()   : per-stage, per-column height / adder counts, used at
//                   elaboration time to wire the reduction tree.
package dadda_8_pkg;

   localparam int unsigned A_W     = 8;
   localparam int unsigned B_W     = 8;
   localparam int unsigned P_W     = 16;
   localparam int unsigned N_STAGE = 4;

   localparam int unsigned DADDA_H [N_STAGE] = '{6, 4, 3, 2};

`ifdef DADDA_8_IN_REG_EN
   localparam int unsigned LATENCY = 2;
`else
   localparam int unsigned LATENCY = 1;
`endif

   typedef enum logic [1:0] {
      TI_HEIGHT,   // bits present in the column at the stage input
      TI_FA,       // full adders placed in the column
      TI_HA,       // half adders placed in the column
      TI_CIN       // carries arriving from the column below
   } tree_q_e;

   // Walks the Dadda schedule from the initial partial-product diamond.
   // Carries produced in column c-1 land in column c within the same stage,
   // so the excess over the target is computed including them; that gives
   // the minimal FA/HA mix (excess/2 FAs, excess%2 HAs) per column.
   // Stage N_STAGE (HEIGHT only) returns the final two-row heights.
   function automatic int unsigned tree_info(input int unsigned stg,
                                             input int unsigned col,
                                             input tree_q_e     what);
      int unsigned h   [P_W];
      int unsigned nh  [P_W];
      int unsigned cin;
      int unsigned ex;
      int unsigned fa;
      int unsigned ha;
      int unsigned res;
      res = 0;
      for (int unsigned c = 0; c < P_W; c++) begin
         h[c] = (c < A_W) ? c + 1 : ((c < P_W - 1) ? P_W - 1 - c : 0);
         nh[c] = 0;
      end
      for (int unsigned s = 0; s < N_STAGE; s++) begin
         cin = 0;
         for (int unsigned c = 0; c < P_W; c++) begin
            ex = (h[c] + cin > DADDA_H[s]) ? h[c] + cin - DADDA_H[s] : 0;
            fa = ex / 2;
            ha = ex % 2;
            if (s == stg && c == col) begin
               case (what)
                  TI_HEIGHT: res = h[c];
                  TI_FA:     res = fa;
                  TI_HA:     res = ha;
                  default:   res = cin;
               endcase
            end
            nh[c] = h[c] + cin - 2 * fa - ha;
            cin   = fa + ha;
         end
         for (int unsigned c = 0; c < P_W; c++) h[c] = nh[c];
      end
      if (stg == N_STAGE && what == TI_HEIGHT) res = h[col];
      return res;
   endfunction

endpackage

// File: rtl/dadda_8_fa.sv
// dadda_fa -- 1-bit full adder, used for every 3:2 reduction cell and every
// bit of the final carry-propagate adder.
//   a, b, cin : addend bits
//   sum, cout : sum bit and carry out
module dadda_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/dadda_8.sv
// dadda_8 -- 8x8 unsigned Dadda multiplier with registered 16-bit product.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears y (and the input register)
//   A   : 8-bit unsigned multiplicand
//   B   : 8-bit unsigned multiplier
//   y   : 16-bit registered product A*B
// Build option: define DADDA_8_IN_REG_EN to register A/B ahead of the tree
// (latency 2 instead of 1, same results and throughput).
module dadda_8
   import dadda_8_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [A_W-1:0] A,
   input  logic [B_W-1:0] B,
   output logic [P_W-1:0] y
);

   logic [A_W-1:0] a_t;
   logic [B_W-1:0] b_t;

`ifdef DADDA_8_IN_REG_EN
   logic [A_W-1:0] a_q;
   logic [B_W-1:0] b_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= A;
         b_q <= B;
      end
   end

   assign a_t = a_q;
   assign b_t = b_q;
`else
   assign a_t = A;
   assign b_t = B;
`endif

   // bits[s][c][k]: k-th dot of column c entering stage s (stage N_STAGE is
   // the final two rows). Each stage's output column is packed as
   // FA sums, HA sums, untouched dots, then carries from column c-1.
   logic bits [N_STAGE+1][P_W][8];
   logic fc   [N_STAGE][P_W][2];
   logic hc   [N_STAGE][P_W];

   for (genvar c = 0; c < P_W; c++) begin : g_pp_col
      localparam int unsigned H0   = tree_info(0, c, TI_HEIGHT);
      localparam int unsigned I_LO = (c > A_W - 1) ? c - (A_W - 1) : 0;
      for (genvar k = 0; k < H0; k++) begin : g_pp
         assign bits[0][c][k] = a_t[c - I_LO - k] & b_t[I_LO + k];
      end
   end

   for (genvar s = 0; s < N_STAGE; s++) begin : g_stage
      for (genvar c = 0; c < P_W; c++) begin : g_col
         localparam int unsigned H    = tree_info(s, c, TI_HEIGHT);
         localparam int unsigned NFA  = tree_info(s, c, TI_FA);
         localparam int unsigned NHA  = tree_info(s, c, TI_HA);
         localparam int unsigned NPT  = H - 3 * NFA - 2 * NHA;
         localparam int unsigned B_CY = NFA + NHA + NPT;

         for (genvar k = 0; k < NFA; k++) begin : g_fa
            dadda_fa u_fa (
               .a    (bits[s][c][3*k]),
               .b    (bits[s][c][3*k+1]),
               .cin  (bits[s][c][3*k+2]),
               .sum  (bits[s+1][c][k]),
               .cout (fc[s][c][k])
            );
         end

         if (NHA > 0) begin : g_ha
            assign bits[s+1][c][NFA] = bits[s][c][3*NFA] ^ bits[s][c][3*NFA+1];
            assign hc[s][c]          = bits[s][c][3*NFA] & bits[s][c][3*NFA+1];
         end

         for (genvar p = 0; p < NPT; p++) begin : g_pt
            assign bits[s+1][c][NFA+NHA+p] = bits[s][c][3*NFA+2*NHA+p];
         end

         if (c > 0) begin : g_cy
            localparam int unsigned PFA = tree_info(s, c - 1, TI_FA);
            localparam int unsigned PHA = tree_info(s, c - 1, TI_HA);
            for (genvar q = 0; q < PFA; q++) begin : g_fcy
               assign bits[s+1][c][B_CY+q] = fc[s][c-1][q];
            end
            if (PHA > 0) begin : g_hcy
               assign bits[s+1][c][B_CY+PFA] = hc[s][c-1];
            end
         end
      end
   end

   // Final ripple adder over columns 1..14; column 0 is a lone dot and
   // column 15 only receives the ripple carry-out.
   logic [P_W-2:1] r0;
   logic [P_W-2:1] r1;
   logic [P_W-2:1] ps;
   logic [P_W-2:0] cp;

   assign cp[0] = 1'b0;

   for (genvar c = 1; c < P_W - 1; c++) begin : g_cpa
      localparam int unsigned HF = tree_info(N_STAGE, c, TI_HEIGHT);
      if (HF > 0) begin : g_r0
         assign r0[c] = bits[N_STAGE][c][0];
      end else begin : g_r0z
         assign r0[c] = 1'b0;
      end
      if (HF > 1) begin : g_r1
         assign r1[c] = bits[N_STAGE][c][1];
      end else begin : g_r1z
         assign r1[c] = 1'b0;
      end
      dadda_fa u_cpa (
         .a    (r0[c]),
         .b    (r1[c]),
         .cin  (cp[c-1]),
         .sum  (ps[c]),
         .cout (cp[c])
      );
   end

   logic [P_W-1:0] y_d;
   logic [P_W-1:0] y_q;

   assign y_d = {cp[P_W-2], ps, a_t[0] & b_t[0]};

   always_ff @(posedge clk) begin
      if (rst) y_q <= '0;
      else     y_q <= y_d;
   end

   assign y = y_q;

endmodule

// File: tb/tb_dadda_8.sv
// tb_dadda_8 -- self-checking bench for dadda_8 (either build of
// DADDA_8_IN_REG_EN). Reference: y after edge n is 0 if rst was high at any
// of the last LAT edges, otherwise the arithmetic product of the operands
// applied LAT-1 edges earlier.
module tb_dadda_8;

`ifdef DADDA_8_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] y;

   int errors;
   int checks;

   logic [7:0] hist_a [$];
   logic [7:0] hist_b [$];
   bit         hist_r [$];

   dadda_8 dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   function automatic logic [15:0] model_y();
      int n;
      n = hist_r.size() - 1;
      for (int k = 0; k < LAT; k++) begin
         if (n - k < 0) return 16'h0000;
         if (hist_r[n-k]) return 16'h0000;
      end
      return 16'(hist_a[n-LAT+1]) * 16'(hist_b[n-LAT+1]);
   endfunction

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL *ERROR* %s: y=%h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Apply one set of inputs across one rising edge, then compare against
   // the reference model.
   task automatic tick(input logic [7:0] a, input logic [7:0] b, input logic r, input string nm);
      A   = a;
      B   = b;
      rst = r;
      @(posedge clk);
      hist_a.push_back(a);
      hist_b.push_back(b);
      hist_r.push_back(r);
      #1;
      check(nm, y, model_y());
   endtask

   initial begin
      vec_t        tbl [8];
      logic [15:0] seq_exp [3];
      logic [7:0]  seq_a [3];
      logic [7:0]  seq_b [3];
      logic [15:0] idx;

      errors = 0;
      checks = 0;
      A      = 8'h00;
      B      = 8'h00;
      rst    = 1'b1;

      tbl[0] = '{8'hAA, 8'h55, 16'h3872};
      tbl[1] = '{8'h0F, 8'hF0, 16'h0E10};
      tbl[2] = '{8'hFF, 8'hFF, 16'hFE01};
      tbl[3] = '{8'h00, 8'hFF, 16'h0000};
      tbl[4] = '{8'hFF, 8'h01, 16'h00FF};
      tbl[5] = '{8'h80, 8'h80, 16'h4000};
      tbl[6] = '{8'h7F, 8'h81, 16'h3FFF};
      tbl[7] = '{8'h01, 8'h01, 16'h0001};

      // Reset held with max operands, then release.
      for (int i = 0; i < 2; i++) begin
         tick(8'hFF, 8'hFF, 1'b1, "rst_model");
         check("rst_hold", y, 16'h0000);
      end
      for (int i = 0; i < LAT; i++) tick(8'hFF, 8'hFF, 1'b0, "rel_model");
      check("rst_release_max", y, 16'hFE01);

      // Back-to-back differing operands.
      seq_a = '{8'h00, 8'h01, 8'h80};
      seq_b = '{8'hB7, 8'hA5, 8'h02};
      seq_exp = '{16'h0000, 16'h00A5, 16'h0100};
      for (int t = 0; t < 3 + LAT - 1; t++) begin
         if (t < 3) tick(seq_a[t], seq_b[t], 1'b0, "seq_model");
         else       tick(8'h33, 8'h44, 1'b0, "seq_model");
         if (t >= LAT - 1) check("seq_const", y, seq_exp[t-LAT+1]);
      end

      // Table vectors, each held for LAT edges.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < LAT; k++) tick(tbl[i].a, tbl[i].b, 1'b0, "tbl_model");
         check("tbl_const", y, tbl[i].exp);
      end

      // Random pairs.
      for (int i = 0; i < 20; i++)
         tick(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0, "rand");

      // Mid-stream reset.
      for (int i = 0; i < 5; i++)
         tick(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0, "pre_rst");
      tick(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1, "mid_rst_model");
      check("mid_rst_zero", y, 16'h0000);
      for (int i = 0; i < 6; i++)
         tick(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0, "post_rst");

      // Exhaustive sweep of every operand pair.
      for (int i = 0; i < 65536; i++) begin
         idx = 16'(i);
         tick(idx[15:8], idx[7:0], 1'b0, "sweep");
      end
      for (int i = 0; i < LAT; i++) tick(8'h00, 8'h00, 1'b0, "drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
